// File: rtl/part_sram_pkg.sv
// Shared types, constants and elaboration helpers for the part_sram_sync memory.
package part_sram_pkg;

    // Sequencer states: sweeping the array with the fill value, or serving users.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Same-address read-during-write selection.
    localparam bit RDW_OLD = 1'b0;
    localparam bit RDW_NEW = 1'b1;

    // Only one- and two-stage read pipelines are supported.
    function automatic bit rd_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/part_sram_if.sv
// User-side bus of part_sram_sync: clear control, write port and read port.
interface part_sram_if #(
    parameter int AW = 12,
    parameter int DW = 1
);
    logic          clear_req;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          err;

    modport master (
        output clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid, err
    );

    modport slave (
        input  clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid, err
    );
endinterface

// File: rtl/part_sram_rdpipe.sv
// Read data/valid pipeline. Each stage only loads data alongside a valid bit,
// so the last stage holds the most recent result between reads.
module part_sram_rdpipe #(
    parameter int DW  = 1,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    for (genvar g = 0; g < LAT; g++) begin : g_stage
        logic          vin_s;
        logic [DW-1:0] din_s;
        logic          vld_r;
        logic [DW-1:0] dat_r;

        if (g == 0) begin : g_first
            assign vin_s = in_valid;
            assign din_s = in_data;
        end else begin : g_next
            assign vin_s = g_stage[g-1].vld_r;
            assign din_s = g_stage[g-1].dat_r;
        end

        // Advance one pipeline stage; data is captured only with a valid beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                dat_r <= {DW{1'b0}};
            end else begin
                vld_r <= vin_s;
                if (vin_s) begin
                    dat_r <= din_s;
                end
            end
        end
    end

    assign out_valid = g_stage[LAT-1].vld_r;
    assign out_data  = g_stage[LAT-1].dat_r;

endmodule

// File: rtl/part_sram_sync.sv
// Synchronous 1W/1R memory with configurable latency, read-during-write
// behaviour and a clear sequencer that fills the array with a fixed value.
module part_sram_sync #(
    parameter int            AW             = 12,
    parameter int            DW             = 1,
    parameter int            RD_LAT         = 1,
    parameter bit            RDW_NEW        = 1'b0,
    parameter bit            CLEAR_ON_RESET = 1'b1,
    parameter logic [DW-1:0] CLEAR_VALUE    = {DW{1'b0}}
) (
    input  logic            clk,
    input  logic            reset_n,
    part_sram_if.slave      bus
);
    import part_sram_pkg::*;

    localparam int      DEPTH      = 2 ** AW;
    localparam bit      BYPASS_NEW = (RDW_NEW == part_sram_pkg::RDW_NEW);
    localparam state_t  RESET_ST   = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    localparam [AW-1:0] LAST_ADDR  = {AW{1'b1}};

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("part_sram_sync: RD_LAT must be 1 or 2");
    end

    logic [DW-1:0] mem_r [0:DEPTH-1];

    state_t        state_r;
    logic          busy_r;
    logic          err_r;
    logic [AW-1:0] clr_addr_r;

    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [DW-1:0] mem_wdata_s;
    logic          rd_fire_s;
    logic [DW-1:0] rd_word_s;
    logic          pipe_valid_s;
    logic [DW-1:0] pipe_data_s;

    // Clear sequencer: walks clr_addr over the array, then serves users until a clear request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= RESET_ST;
            busy_r     <= CLEAR_ON_RESET;
            err_r      <= 1'b0;
            clr_addr_r <= {AW{1'b0}};
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    err_r <= bus.wr_en | bus.rd_en;
                    if (clr_addr_r == LAST_ADDR) begin
                        state_r    <= ST_READY;
                        busy_r     <= 1'b0;
                        clr_addr_r <= {AW{1'b0}};
                    end else begin
                        clr_addr_r <= clr_addr_r + AW'(1'b1);
                    end
                end
                ST_READY: begin
                    if (bus.clear_req) begin
                        state_r    <= ST_CLEAR;
                        busy_r     <= 1'b1;
                        clr_addr_r <= {AW{1'b0}};
                    end
                end
                default: begin
                    state_r    <= RESET_ST;
                    busy_r     <= CLEAR_ON_RESET;
                    clr_addr_r <= {AW{1'b0}};
                end
            endcase
        end
    end

    // Select the array write source and the word entering the read pipeline.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.wr_addr;
        mem_wdata_s = bus.wr_data;
        rd_fire_s   = 1'b0;
        rd_word_s   = mem_r[bus.rd_addr];
        if (state_r == ST_CLEAR) begin
            mem_we_s    = reset_n;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = CLEAR_VALUE;
        end else begin
            mem_we_s  = bus.wr_en & reset_n;
            rd_fire_s = bus.rd_en;
            if (BYPASS_NEW && bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
                rd_word_s = bus.wr_data;
            end else begin
                rd_word_s = mem_r[bus.rd_addr];
            end
        end
    end

    // Array write port; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    part_sram_rdpipe #(
        .DW  (DW),
        .LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (clk),
        .rst_n     (reset_n),
        .in_valid  (rd_fire_s),
        .in_data   (rd_word_s),
        .out_valid (pipe_valid_s),
        .out_data  (pipe_data_s)
    );

    assign bus.busy     = busy_r;
    assign bus.err      = err_r;
    assign bus.rd_valid = pipe_valid_s;
    assign bus.rd_data  = pipe_data_s;

endmodule
